led_afterglow: RTL

Downstream output stage for the LED pattern generators: takes the 10-bit pattern word a generator drives and produces the board's 10 LED lines with a per-LED afterglow. A lit pattern bit drives its LED to full brightness. After the bit drops, brightness decays in steps, rendered with a shared PWM counter. A bypass input restores plain on/off display.

---
 rtl/led_pkg.sv | 7 +
 rtl/led_afterglow_if.sv | 13 +
 rtl/led_glow_channel.sv | 34 +++
 rtl/led_afterglow.sv | 47 ++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED definitions used by the pattern generators and the output stage.
package led_pkg;
  localparam int NUM_LEDS       = 10;
  localparam int LEVEL_BITS_DEF = 4;

  typedef logic [NUM_LEDS-1:0] led_vec_t;
endpackage

// File: rtl/led_afterglow_if.sv
// Generator-to-output-stage bundle: pattern word and controls in, LED drive and idle out.
interface led_afterglow_if;
  import led_pkg::*;

  logic     en;
  logic     bypass;
  led_vec_t pattern_in;
  led_vec_t led_out;
  logic     idle;

  modport master (output en, bypass, pattern_in, input  led_out, idle);
  modport slave  (input  en, bypass, pattern_in, output led_out, idle);
endinterface

// File: rtl/led_glow_channel.sv
// One LED: brightness level with reload/decay, plus PWM rendering or bypass.
module led_glow_channel #(
  parameter int LEVEL_BITS = led_pkg::LEVEL_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pattern_bit,
  input  logic                  decay_tick,
  input  logic [LEVEL_BITS-1:0] pwm,
  input  logic                  bypass,
  output logic                  led,
  output logic                  level_zero
);
  localparam logic [LEVEL_BITS-1:0] MAX = '1;

  logic [LEVEL_BITS-1:0] level;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      // reload beats a coincident decay tick; decay saturates at zero
      if (pattern_bit)
        level <= MAX;
      else if (decay_tick && level != '0)
        level <= level - LEVEL_BITS'(1);
      // MAX is forced fully on, otherwise duty = level / 2^LEVEL_BITS
      led <= bypass ? pattern_bit : ((level == MAX) || (level > pwm));
    end
  end

  assign level_zero = (level == '0);
endmodule

// File: rtl/led_afterglow.sv
// LED output stage with per-LED afterglow: shared decay divider and PWM counter feed 10 channels.
module led_afterglow
  import led_pkg::*;
#(
  parameter int LEVEL_BITS     = LEVEL_BITS_DEF,
  parameter int DECAY_DIV_BITS = 20
) (
  input  logic           clk,
  input  logic           rst,
  led_afterglow_if.slave bus
);
  logic [DECAY_DIV_BITS-1:0] div;
  logic [LEVEL_BITS-1:0]     pwm;
  logic                      decay_tick;
  led_vec_t                  led_d;
  led_vec_t                  level_zero;

  assign decay_tick = bus.en & (&div);

  // pwm free-runs independent of en so frozen levels stay visible
  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      pwm      <= '0;
      bus.idle <= 1'b1;
    end else begin
      if (bus.en) div <= div + DECAY_DIV_BITS'(1);
      pwm      <= pwm + LEVEL_BITS'(1);
      bus.idle <= &level_zero;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_glow_channel #(.LEVEL_BITS(LEVEL_BITS)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .pattern_bit (bus.pattern_in[i]),
      .decay_tick  (decay_tick),
      .pwm         (pwm),
      .bypass      (bus.bypass),
      .led         (led_d[i]),
      .level_zero  (level_zero[i])
    );
  end

  assign bus.led_out = led_d;
endmodule
